// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the iterative FP divider.
//   - state_t : divider FSM state encoding
//   - EXP_W / MAN_W / BIAS : IEEE-754 single-precision field widths and bias
//   - REM_W : width of the restoring-divider partial remainder
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int REM_W = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/fdiv_iter_step.sv
// fdiv_iter_step: one restoring radix-2 division step (compare, subtract, shift).
// Ports:
//   rem      - current partial remainder (REM_W bits)
//   dvs      - divisor significand 1.m (MAN_W+1 bits)
//   qbit     - quotient bit produced by this step
//   rem_next - remainder for the next step, already shifted left by one
module fdiv_iter_step
    import fpu_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [MAN_W:0]   dvs,
    output logic             qbit,
    output logic [REM_W-1:0] rem_next
);

    logic [REM_W-1:0] dvs_ext;
    logic [REM_W-1:0] diff;

    always_comb begin
        dvs_ext  = {{(REM_W-MAN_W-1){1'b0}}, dvs};
        diff     = rem - dvs_ext;
        qbit     = (rem >= dvs_ext);
        // The kept remainder is always below the divisor, so the top bit
        // dropped by the shift is zero.
        rem_next = qbit ? {diff[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};
    end

endmodule

// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single-precision divider, fixed latency.
// A request accepted in IDLE produces y = x1 / x2 with a one-cycle valid
// pulse exactly QBITS+2 cycles after the accept edge. Denormals are flushed
// to zero, exponent 255 is treated as infinity, rounding is nearest-even.
// Optional feature macro: FDIV_EXC_EN adds the flags output.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   x1    - dividend
//   x2    - divisor
//   req   - start request, sampled only while busy=0
//   y     - quotient, held until the next result
//   valid - one-cycle pulse marking a new y
//   busy  - high from accept edge through the valid cycle
//   flags - (FDIV_EXC_EN only) bit0 divide-by-zero, bit1 overflow
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        req,
    output logic [31:0] y,
    output logic        valid,
`ifdef FDIV_EXC_EN
    output logic        busy,
    output logic [1:0]  flags
`else
    output logic        busy
`endif
);

    localparam int CNT_W = $clog2(QBITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QBITS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [REM_W-1:0] rem;
    logic [QBITS-1:0] q;

    logic             qbit;
    logic [REM_W-1:0] rem_next;

    fdiv_iter_step u_step (
        .rem      (rem),
        .dvs      ({1'b1, b_r[MAN_W-1:0]}),
        .qbit     (qbit),
        .rem_next (rem_next)
    );

    // Normalise, round and resolve special cases from the finished quotient.
    logic             sgn;
    logic [EXP_W-1:0] e1, e2;
    logic             z1, z2, i1, i2;
    logic             norm, g, r, s, up, carry;
    logic [MAN_W:0]   mant_pre;
    logic [MAN_W+1:0] mant_sum;
    logic [MAN_W-1:0] frac;
    logic [9:0]       e_res;
    logic             ovf, unf;
    logic [31:0]      res_y;

    always_comb begin
        sgn = a_r[31] ^ b_r[31];
        e1  = a_r[MAN_W +: EXP_W];
        e2  = b_r[MAN_W +: EXP_W];
        z1  = (e1 == '0);
        z2  = (e2 == '0);
        i1  = (e1 == '1);
        i2  = (e2 == '1);

        norm     = q[QBITS-1];
        mant_pre = norm ? q[QBITS-1:2] : q[QBITS-2:1];
        g        = norm ? q[1] : q[0];
        r        = norm ? q[0] : 1'b0;
        s        = (rem != '0);
        up       = g & (r | s | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + {{(MAN_W+1){1'b0}}, up};
        carry    = mant_sum[MAN_W+1];
        frac     = carry ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];

        e_res = {2'b00, e1} - {2'b00, e2} + 10'(BIAS)
              - {9'b0, ~norm} + {9'b0, carry};
        ovf   = ($signed(e_res) >= 10'sd255);
        unf   = ($signed(e_res) <= 10'sd0);

        if (z2)        res_y = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (z1)   res_y = {sgn, 31'b0};
        else if (i1)   res_y = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (i2)   res_y = {sgn, 31'b0};
        else if (ovf)  res_y = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)  res_y = {sgn, 31'b0};
        else           res_y = {sgn, e_res[EXP_W-1:0], frac};
    end

`ifdef FDIV_EXC_EN
    logic [1:0] res_flags;
    always_comb begin
        res_flags    = '0;
        res_flags[0] = z2 & ~z1;
        res_flags[1] = ~(z1 | z2 | i1 | i2) & ovf;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            rem   <= '0;
            q     <= '0;
            y     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
`ifdef FDIV_EXC_EN
            flags <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req && !busy) begin
                        a_r   <= x1;
                        b_r   <= x2;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DIV;
                    end
                end
                DIV: begin
                    // First DIV cycle seeds the remainder with the dividend
                    // significand; the QBITS steps follow, which yields the
                    // fixed QBITS+2 latency to the valid cycle.
                    if (cnt == '0) begin
                        rem <= {{(REM_W-MAN_W-1){1'b0}}, 1'b1, a_r[MAN_W-1:0]};
                    end else begin
                        rem <= rem_next;
                        q   <= {q[QBITS-2:0], qbit};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= RND;
                end
                RND: begin
                    y     <= res_y;
                    valid <= 1'b1;
`ifdef FDIV_EXC_EN
                    flags <= res_flags;
`endif
                    state <= OUT;
                end
                OUT: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: scoreboard bench for fdiv_iter. Expected results come from an
// integer long-division reference model; a monitor pops and compares on valid.
module tb_fdiv_iter;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        req  = 1'b0;
    logic [31:0] x1   = '0;
    logic [31:0] x2   = '0;
    logic [31:0] y;
    logic        valid;
    logic        busy;
`ifdef FDIV_EXC_EN
    logic [1:0]  flags;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int next_free = 0;

    typedef struct {
        logic [31:0] y;
        logic [1:0]  fl;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fdiv_iter #(.QBITS(26)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .x1    (x1),
        .x2    (x2),
        .req   (req),
        .y     (y),
        .valid (valid),
`ifdef FDIV_EXC_EN
        .busy  (busy),
        .flags (flags)
`else
        .busy  (busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // Reference: quotient of the significands by integer division, then
    // round-to-nearest-even on the dropped bits plus the division remainder.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   rr;
        logic   sg;
        int     e1, e2, ex, sh;
        longint m1, m2, num, qt, rm, mant, drop, half;
        logic [31:0] mv;
        sg = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        rr.acc = 0;
        rr.fl  = 2'b00;
        if (e2 == 0) begin
            rr.y  = {sg, 8'hFF, 23'h0};
            rr.fl = (e1 != 0) ? 2'b01 : 2'b00;
            return rr;
        end
        if (e1 == 0)   begin rr.y = {sg, 31'h0};         return rr; end
        if (e1 == 255) begin rr.y = {sg, 8'hFF, 23'h0};  return rr; end
        if (e2 == 255) begin rr.y = {sg, 31'h0};         return rr; end
        m1  = longint'({1'b1, a[22:0]});
        m2  = longint'({1'b1, b[22:0]});
        num = m1 << 25;
        qt  = num / m2;
        rm  = num % m2;
        ex  = e1 - e2 + 127;
        if (qt >= (longint'(1) << 25)) sh = 2;
        else begin sh = 1; ex = ex - 1; end
        mant = qt >> sh;
        drop = qt & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        if (drop > half || (drop == half && (rm != 0 || mant[0]))) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin mant = mant >> 1; ex = ex + 1; end
        if (ex >= 255) begin
            rr.y  = {sg, 8'hFF, 23'h0};
            rr.fl = 2'b10;
        end else if (ex <= 0) begin
            rr.y = {sg, 31'h0};
        end else begin
            mv   = 32'(mant);
            rr.y = {sg, 8'(ex), mv[22:0]};
        end
        return rr;
    endfunction

    // Drives one request. The accept edge is predicted from the protocol:
    // the earliest free edge is 30 edges after the previous accept. With
    // early=1 req is raised during the previous OUT cycle and held.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic [1:0] ef, input bit early);
        int   t;
        exp_t e;
        t = next_free;
        if (t <= cyc) t = cyc + 1;
        while (cyc < t - (early ? 2 : 1)) @(negedge clk);
        x1  = a;
        x2  = b;
        req = 1'b1;
        while (cyc < t) @(negedge clk);
        req = 1'b0;
        x1  = $urandom;
        x2  = $urandom;
        e.y = ey; e.fl = ef; e.acc = t;
        sb.push_back(e);
        next_free = t + 30;
    endtask

    task automatic issue_m(input logic [31:0] a, input logic [31:0] b, input bit early);
        exp_t m;
        m = model(a, b);
        issue(a, b, m.y, m.fl, early);
    endtask

    function automatic logic [31:0] rand_fp();
        int          cat;
        logic [7:0]  e;
        logic [31:0] r;
        cat = $urandom_range(0, 9);
        if (cat == 0)      e = 8'd0;
        else if (cat == 1) e = 8'd255;
        else if (cat < 5)  e = 8'($urandom_range(1, 254));
        else               e = 8'($urandom_range(90, 164));
        r = $urandom;
        return {r[31], e, r[22:0]};
    endfunction

    // Monitor: every valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid at cycle %0d: got y=%h required no valid", cyc, y);
                end else begin
                    e = sb.pop_front();
                    chk("y", y, e.y);
                    chk("latency", 32'(cyc - e.acc), 32'd28);
                    chk("busy_in_valid", {31'b0, busy}, 32'd1);
`ifdef FDIV_EXC_EN
                    chk("flags", {30'b0, flags}, {30'b0, e.fl});
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int   a;
        int   w;
        exp_t dummy;
        logic [31:0] dx1 [10];
        logic [31:0] dx2 [10];
        logic [31:0] dy  [10];
        logic [1:0]  dfl [10];

        dx1 = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000,
                32'h00800000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'hC0C00000};
        dx2 = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h40A00000, 32'h3E800000,
                32'h7F000000, 32'h00000000, 32'h7F800000, 32'h7F800000, 32'h40000000};
        dy  = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h00000000, 32'h7F800000,
                32'h00000000, 32'h7F800000, 32'h7F800000, 32'h00000000, 32'hC0400000};
        dfl = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        // Asynchronous reset with no clock edge involved.
        #1 rstn = 1'b0;
        #2;
        chk("reset_y",     y,              32'h0);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_busy",  {31'b0, busy},  32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        next_free = cyc + 1;

        // Directed vectors with fixed expectations.
        for (int i = 0; i < 10; i++) issue(dx1[i], dx2[i], dy[i], dfl[i], 1'b0);

        // Back-to-back with req raised in the OUT cycle.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 1'b0);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, 1'b1);

        // req during busy with other operands must be ignored.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 1'b0);
        a = next_free - 30;
        while (cyc < a + 2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            x1  = 32'h3F800000;
            x2  = 32'h40400000;
            req = 1'b1;
            @(negedge clk);
        end
        req = 1'b0;

        // Reset 10 cycles into an operation aborts it.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, 1'b0);
        a = next_free - 30;
        while (cyc < a + 10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_busy",  {31'b0, busy},  32'h0);
        chk("abort_valid", {31'b0, valid}, 32'h0);
        chk("abort_y",     y,              32'h0);
        dummy = sb.pop_back();
        @(negedge clk);
        rstn = 1'b1;
        next_free = cyc + 1;
        repeat (40) @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, 1'b0);

        // Randomised operands against the reference model.
        for (int i = 0; i < 120; i++) begin
            issue_m(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drained", 32'(sb.size()), 32'h0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
